score_update_sequencer: RTL and testbench
=========================================

// Module: score_update_sequencer
// PURPOSE
//  Serialises score-change commands from two team panels onto one shared saturating add/sub unit.
//  Owns the two team score registers and feeds them to the display/BCD path.
//  Inputs are single-cycle event pulses from the debounce/edge-detect front end.
//  Each team has a one-deep pending command slot; the slots are served round-robin.
// PARAMETERS
//  SCORE_W    16    width of each score register
//  MAX_SCORE  9999  saturation ceiling; must fit in SCORE_W
// PORTS
//  clk            in   1        system clock
//  reset          in   1        asynchronous, active-high reset
//  t_inc          in   2        per-team increment event pulse; [0]=team1, [1]=team2
//  t_dec          in   2        per-team decrement event pulse
//  t_clr          in   2        per-team clear event pulse
//  step_sel       in   3        step size = step_sel+1 (1..8); sampled when a command is captured
//  score_team1    out  SCORE_W  team 1 score
//  score_team2    out  SCORE_W  team 2 score
//  busy           out  1        FSM is not in IDLE
//  update_pulse   out  1        one-cycle pulse after a score register write
//  upd_team       out  1        team written by the last update (0=team1); valid with update_pulse
//  drop_pulse     out  2        one-cycle pulse per team when an event is discarded
// BEHAVIOUR
//  Reset values: scores=0, slots empty, FSM=IDLE, rr pointer=team1, and all outputs 0.
//  Capture, per team, each cycle:
//   - Priority among simultaneous pulses: clr > inc > dec. Lower-priority pulses are ignored and do not drop.
//   - clr always overwrites the slot.
//   - inc/dec with an empty slot: stored as {cmd, step}.
//   - inc/dec with a full slot: discarded, and drop_pulse[team] fires next cycle.
//   - A capture in the same cycle the slot is granted is kept: the new command refills the slot.
//  FSM states: IDLE, EXEC.
//   - IDLE: if any slot is full, grant one. If both are full, grant the team the rr pointer names, then flip the pointer past the winner.
//     Latch team/cmd/step, clear the slot, and go to EXEC.
//   - EXEC: compute and write the score, pulse update_pulse/upd_team, and go to IDLE.
//  Arithmetic, evaluated with one extra bit:
//   - inc: min(score+step, MAX_SCORE)
//   - dec: (score>=step) ? score-step : 0
//   - clr: 0
//  Latency: an event sampled at edge E0 is granted at E1 and written at E2. Peak throughput is one command per 2 cycles.
//  Reset mid-EXEC: the write is abandoned and all state returns to reset values.
// CONFIGURATION
//  SCORE_UNDO_EN defined:
//   - Adds input undo_i (1-bit pulse) and a one-deep history {team, old_score, valid}, loaded on every EXEC write.
//   - In IDLE, a pending undo beats both team slots.
//   - An undo restores old_score to the recorded team, pulses update_pulse, and clears valid.
//   - An undo with valid=0 is ignored.
//   - The pending undo flag holds through EXEC.
//  SCORE_UNDO_EN undefined: no undo_i port and no history registers.
// STRUCTURE
//  Package score_pkg holds:
//   - cmd_t enum {CMD_NONE, CMD_INC, CMD_DEC, CMD_CLR}
//   - state_t enum {ST_IDLE, ST_EXEC}
//   - MAX_SCORE_DEF=9999 and STEP_W=4
//  Sub-module score_alu is purely combinational: (score, cmd, step) -> saturated next score.
//  Both teams share one score_alu instance; this is the resource being sequenced.
// TESTING
//  1 t_inc[0] pulse, step_sel=2 -> score_team1=3 written 2 edges later; update_pulse=1, upd_team=0.
//  2 t_inc=2'b11 in the same cycle, step_sel=0 -> team1 updated first, team2 2 cycles later, both =1; next tie goes to team2 first.
//  3 score_team2=9997, t_inc[1], step_sel=7 -> 9999; score_team1=3, t_dec[0], step_sel=7 -> 0.
//  4 While busy and team1 slot full, t_inc[0] again -> drop_pulse[0] next cycle, only one increment applied; t_clr[0] instead -> score_team1=0.
//  5 t_clr[0]&t_inc[0] in one cycle -> score_team1=0 and no drop; reset asserted during EXEC -> all scores 0, busy=0.
//  6 (SCORE_UNDO_EN) team1 5->9 via inc, then undo_i -> score_team1=5; second undo_i -> no change and no update_pulse.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the score update sequencer.
package score_pkg;

  typedef enum logic [1:0] {CMD_NONE, CMD_INC, CMD_DEC, CMD_CLR} cmd_t;

  typedef enum logic {ST_IDLE, ST_EXEC} state_t;

  localparam int unsigned MAX_SCORE_DEF = 9999;
  localparam int unsigned STEP_W        = 4;

endpackage

// File: rtl/score_alu.sv
// Combinational saturating add/sub shared by both teams.
module score_alu
  import score_pkg::*;
#(
  parameter int unsigned SCORE_W   = 16,
  parameter int unsigned MAX_SCORE = MAX_SCORE_DEF
) (
  input  logic [SCORE_W-1:0] score_i,
  input  cmd_t               cmd_i,
  input  logic [STEP_W-1:0]  step_i,
  output logic [SCORE_W-1:0] score_o
);

  localparam logic [SCORE_W:0] MaxExt = (SCORE_W+1)'(MAX_SCORE);

  logic [SCORE_W:0] score_ext, step_ext, sum, diff;

  assign score_ext = {1'b0, score_i};
  assign step_ext  = (SCORE_W+1)'(step_i);
  assign sum       = score_ext + step_ext;
  assign diff      = score_ext - step_ext;

  always_comb begin
    score_o = score_i;
    unique case (cmd_i)
      CMD_INC:  score_o = (sum > MaxExt) ? MaxExt[SCORE_W-1:0] : sum[SCORE_W-1:0];
      CMD_DEC:  score_o = (score_ext >= step_ext) ? diff[SCORE_W-1:0] : '0;
      CMD_CLR:  score_o = '0;
      default:  score_o = score_i;
    endcase
  end

endmodule

// File: rtl/score_update_sequencer.sv
// Serialises per-team score commands onto one shared score_alu, round-robin on ties.
// Optional undo of the last write is enabled by defining SCORE_UNDO_EN.
module score_update_sequencer
  import score_pkg::*;
#(
  parameter int unsigned SCORE_W   = 16,
  parameter int unsigned MAX_SCORE = MAX_SCORE_DEF
) (
  input  logic               clk,
  input  logic               reset,
`ifdef SCORE_UNDO_EN
  input  logic               undo_i,
`endif
  input  logic [1:0]         t_inc,
  input  logic [1:0]         t_dec,
  input  logic [1:0]         t_clr,
  input  logic [2:0]         step_sel,
  output logic [SCORE_W-1:0] score_team1,
  output logic [SCORE_W-1:0] score_team2,
  output logic               busy,
  output logic               update_pulse,
  output logic               upd_team,
  output logic [1:0]         drop_pulse
);

  state_t               state_q, state_d;
  logic                 rr_q, rr_d;
  cmd_t                 slot_cmd_q [2];
  cmd_t                 slot_cmd_d [2];
  logic [STEP_W-1:0]    slot_step_q [2];
  logic [STEP_W-1:0]    slot_step_d [2];
  logic [SCORE_W-1:0]   score_q [2];
  logic [SCORE_W-1:0]   score_d [2];
  logic                 exec_team_q, exec_team_d;
  cmd_t                 exec_cmd_q, exec_cmd_d;
  logic [STEP_W-1:0]    exec_step_q, exec_step_d;
  logic                 update_q, update_d;
  logic                 upd_team_q, upd_team_d;
  logic [1:0]           drop_q, drop_d;

  logic [1:0]           slot_full;
  logic                 grant_vld, grant_team, undo_block;
  logic [STEP_W-1:0]    step_cur;
  logic [SCORE_W-1:0]   alu_in, alu_out;

`ifdef SCORE_UNDO_EN
  logic                 undo_pend_q, undo_pend_d;
  logic                 exec_undo_q, exec_undo_d;
  logic                 hist_team_q, hist_team_d;
  logic [SCORE_W-1:0]   hist_old_q, hist_old_d;
  logic                 hist_valid_q, hist_valid_d;
  assign undo_block = undo_pend_q;
`else
  assign undo_block = 1'b0;
`endif

  assign step_cur   = STEP_W'({1'b0, step_sel}) + STEP_W'(1);
  assign slot_full  = {slot_cmd_q[1] != CMD_NONE, slot_cmd_q[0] != CMD_NONE};
  assign grant_team = (&slot_full) ? rr_q : ~slot_full[0];
  // A pending undo takes precedence over both team slots.
  assign grant_vld  = (state_q == ST_IDLE) && (|slot_full) && !undo_block;
  assign alu_in     = score_q[exec_team_q];

  score_alu #(
    .SCORE_W  (SCORE_W),
    .MAX_SCORE(MAX_SCORE)
  ) u_alu (
    .score_i(alu_in),
    .cmd_i  (exec_cmd_q),
    .step_i (exec_step_q),
    .score_o(alu_out)
  );

  // Slot capture: a slot granted this cycle counts as empty, so new events refill it.
  always_comb begin
    drop_d = '0;
    for (int t = 0; t < 2; t++) begin
      slot_cmd_d[t]  = (grant_vld && (grant_team == t[0])) ? CMD_NONE : slot_cmd_q[t];
      slot_step_d[t] = slot_step_q[t];
      if (t_clr[t]) begin
        slot_cmd_d[t]  = CMD_CLR;
        slot_step_d[t] = step_cur;
      end else if (t_inc[t] || t_dec[t]) begin
        if (slot_cmd_d[t] == CMD_NONE) begin
          slot_cmd_d[t]  = t_inc[t] ? CMD_INC : CMD_DEC;
          slot_step_d[t] = step_cur;
        end else begin
          drop_d[t] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    exec_team_d = exec_team_q;
    exec_cmd_d  = exec_cmd_q;
    exec_step_d = exec_step_q;
    score_d     = score_q;
    update_d    = 1'b0;
    upd_team_d  = upd_team_q;
`ifdef SCORE_UNDO_EN
    undo_pend_d  = undo_pend_q;
    exec_undo_d  = exec_undo_q;
    hist_team_d  = hist_team_q;
    hist_old_d   = hist_old_q;
    hist_valid_d = hist_valid_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef SCORE_UNDO_EN
        if (undo_pend_q) begin
          undo_pend_d = 1'b0;
          if (hist_valid_q) begin
            exec_undo_d = 1'b1;
            state_d     = ST_EXEC;
          end
        end
`endif
        if (grant_vld) begin
          if (&slot_full) rr_d = ~grant_team;
          exec_team_d = grant_team;
          exec_cmd_d  = slot_cmd_q[grant_team];
          exec_step_d = slot_step_q[grant_team];
          state_d     = ST_EXEC;
`ifdef SCORE_UNDO_EN
          exec_undo_d = 1'b0;
`endif
        end
      end
      ST_EXEC: begin
        state_d  = ST_IDLE;
        update_d = 1'b1;
`ifdef SCORE_UNDO_EN
        if (exec_undo_q) begin
          score_d[hist_team_q] = hist_old_q;
          upd_team_d           = hist_team_q;
          hist_valid_d         = 1'b0;
        end else begin
          score_d[exec_team_q] = alu_out;
          upd_team_d           = exec_team_q;
          hist_team_d          = exec_team_q;
          hist_old_d           = alu_in;
          hist_valid_d         = 1'b1;
        end
`else
        score_d[exec_team_q] = alu_out;
        upd_team_d           = exec_team_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef SCORE_UNDO_EN
    if (undo_i) undo_pend_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      slot_cmd_q  <= '{default: CMD_NONE};
      slot_step_q <= '{default: '0};
      score_q     <= '{default: '0};
      exec_team_q <= 1'b0;
      exec_cmd_q  <= CMD_NONE;
      exec_step_q <= '0;
      update_q    <= 1'b0;
      upd_team_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      slot_cmd_q  <= slot_cmd_d;
      slot_step_q <= slot_step_d;
      score_q     <= score_d;
      exec_team_q <= exec_team_d;
      exec_cmd_q  <= exec_cmd_d;
      exec_step_q <= exec_step_d;
      update_q    <= update_d;
      upd_team_q  <= upd_team_d;
      drop_q      <= drop_d;
    end
  end

`ifdef SCORE_UNDO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      undo_pend_q  <= 1'b0;
      exec_undo_q  <= 1'b0;
      hist_team_q  <= 1'b0;
      hist_old_q   <= '0;
      hist_valid_q <= 1'b0;
    end else begin
      undo_pend_q  <= undo_pend_d;
      exec_undo_q  <= exec_undo_d;
      hist_team_q  <= hist_team_d;
      hist_old_q   <= hist_old_d;
      hist_valid_q <= hist_valid_d;
    end
  end
`endif

  assign score_team1  = score_q[0];
  assign score_team2  = score_q[1];
  assign busy         = (state_q != ST_IDLE);
  assign update_pulse = update_q;
  assign upd_team     = upd_team_q;
  assign drop_pulse   = drop_q;

endmodule

// File: tb/tb_score_update_sequencer.sv
// Directed self-checking bench for score_update_sequencer; undo cases need SCORE_UNDO_EN.
module tb_score_update_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  t_inc, t_dec, t_clr;
  logic [2:0]  step_sel;
  logic [15:0] score_team1, score_team2;
  logic        busy, update_pulse, upd_team;
  logic [1:0]  drop_pulse;
`ifdef SCORE_UNDO_EN
  logic        undo_i;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  score_update_sequencer #(
    .SCORE_W  (16),
    .MAX_SCORE(9999)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef SCORE_UNDO_EN
    .undo_i      (undo_i),
`endif
    .t_inc       (t_inc),
    .t_dec       (t_dec),
    .t_clr       (t_clr),
    .step_sel    (step_sel),
    .score_team1 (score_team1),
    .score_team2 (score_team2),
    .busy        (busy),
    .update_pulse(update_pulse),
    .upd_team    (upd_team),
    .drop_pulse  (drop_pulse)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Inputs held for exactly one capture edge; returns at the negedge after that edge.
  task automatic pulse(input logic [1:0] inc, input logic [1:0] dec, input logic [1:0] clr,
                       input logic [2:0] sel);
    @(negedge clk);
    t_inc = inc; t_dec = dec; t_clr = clr; step_sel = sel;
    @(negedge clk);
    t_inc = '0; t_dec = '0; t_clr = '0;
  endtask

  task automatic run_cmd(input logic [1:0] inc, input logic [1:0] dec, input logic [1:0] clr,
                         input logic [2:0] sel);
    pulse(inc, dec, clr, sel);
    cyc(2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; t_inc = '0; t_dec = '0; t_clr = '0; step_sel = '0;
`ifdef SCORE_UNDO_EN
    undo_i = 1'b0;
`endif
    #1;
    check_eq("rst_score1", 32'(score_team1), 32'd0);
    check_eq("rst_score2", 32'(score_team2), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_upd", 32'(update_pulse), 32'd0);
    check_eq("rst_drop", 32'(drop_pulse), 32'd0);
    cyc(2);
    reset = 1'b0;

    // Single increment: grant at E1, write visible after E2.
    pulse(2'b01, 2'b00, 2'b00, 3'd2);
    cyc(1);
    check_eq("t1_busy_e1", 32'(busy), 32'd1);
    check_eq("t1_score_e1", 32'(score_team1), 32'd0);
    cyc(1);
    check_eq("t1_score", 32'(score_team1), 32'd3);
    check_eq("t1_upd", 32'(update_pulse), 32'd1);
    check_eq("t1_upd_team", 32'(upd_team), 32'd0);
    cyc(1);
    check_eq("t1_upd_off", 32'(update_pulse), 32'd0);
    check_eq("t1_idle", 32'(busy), 32'd0);

    // Tie: team1 first, then next tie goes to team2 first.
    pulse(2'b11, 2'b00, 2'b00, 3'd0);
    cyc(2);
    check_eq("t2a_team", 32'(upd_team), 32'd0);
    check_eq("t2a_s1", 32'(score_team1), 32'd4);
    check_eq("t2a_s2_wait", 32'(score_team2), 32'd0);
    cyc(2);
    check_eq("t2a_team2", 32'(upd_team), 32'd1);
    check_eq("t2a_s2", 32'(score_team2), 32'd1);
    pulse(2'b11, 2'b00, 2'b00, 3'd0);
    cyc(2);
    check_eq("t2b_team", 32'(upd_team), 32'd1);
    check_eq("t2b_s2", 32'(score_team2), 32'd2);
    cyc(2);
    check_eq("t2b_team1", 32'(upd_team), 32'd0);
    check_eq("t2b_s1", 32'(score_team1), 32'd5);

    // Saturation at both ends.
    do_reset();
    check_eq("t3_rst_s1", 32'(score_team1), 32'd0);
    for (int i = 0; i < 1249; i++) run_cmd(2'b10, 2'b00, 2'b00, 3'd7);
    run_cmd(2'b10, 2'b00, 2'b00, 3'd4);
    check_eq("t3_s2_9997", 32'(score_team2), 32'd9997);
    run_cmd(2'b10, 2'b00, 2'b00, 3'd7);
    check_eq("t3_sat_hi", 32'(score_team2), 32'd9999);
    run_cmd(2'b10, 2'b00, 2'b00, 3'd0);
    check_eq("t3_sat_hold", 32'(score_team2), 32'd9999);
    run_cmd(2'b01, 2'b00, 2'b00, 3'd2);
    check_eq("t3_s1_3", 32'(score_team1), 32'd3);
    run_cmd(2'b00, 2'b01, 2'b00, 3'd7);
    check_eq("t3_sat_lo", 32'(score_team1), 32'd0);
    run_cmd(2'b01, 2'b00, 2'b00, 3'd4);
    run_cmd(2'b00, 2'b01, 2'b00, 3'd2);
    check_eq("t3_dec", 32'(score_team1), 32'd2);

    // Refill on grant, then drop while busy with a full slot.
    @(negedge clk); t_inc = 2'b01; step_sel = 3'd0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    t_inc = 2'b00;
    check_eq("t4_s1_first", 32'(score_team1), 32'd3);
    check_eq("t4_drop", 32'(drop_pulse), 32'd1);
    @(negedge clk);
    check_eq("t4_drop_off", 32'(drop_pulse), 32'd0);
    @(negedge clk);
    check_eq("t4_s1_refill", 32'(score_team1), 32'd4);
    // Clear overwrites a full slot without dropping.
    @(negedge clk); t_inc = 2'b01;
    @(negedge clk);
    @(negedge clk); t_inc = 2'b00; t_clr = 2'b01;
    @(negedge clk); t_clr = 2'b00;
    check_eq("t4_s1_5", 32'(score_team1), 32'd5);
    check_eq("t4_clr_nodrop", 32'(drop_pulse), 32'd0);
    cyc(2);
    check_eq("t4_clr", 32'(score_team1), 32'd0);

    // clr wins over inc in the same cycle.
    run_cmd(2'b01, 2'b00, 2'b00, 3'd6);
    check_eq("t5_s1_7", 32'(score_team1), 32'd7);
    pulse(2'b01, 2'b00, 2'b01, 3'd3);
    check_eq("t5_nodrop", 32'(drop_pulse), 32'd0);
    cyc(2);
    check_eq("t5_clr", 32'(score_team1), 32'd0);

    // Reset during EXEC abandons the write.
    run_cmd(2'b01, 2'b00, 2'b00, 3'd1);
    pulse(2'b10, 2'b00, 2'b00, 3'd7);
    cyc(1);
    check_eq("t5_busy_exec", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_s1", 32'(score_team1), 32'd0);
    check_eq("t5_rst_s2", 32'(score_team2), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(3);
    check_eq("t5_post_s2", 32'(score_team2), 32'd0);
    check_eq("t5_post_upd", 32'(update_pulse), 32'd0);

`ifdef SCORE_UNDO_EN
    run_cmd(2'b01, 2'b00, 2'b00, 3'd4);
    run_cmd(2'b01, 2'b00, 2'b00, 3'd3);
    check_eq("t6_s1_9", 32'(score_team1), 32'd9);
    @(negedge clk); undo_i = 1'b1;
    @(negedge clk); undo_i = 1'b0;
    cyc(2);
    check_eq("t6_undo", 32'(score_team1), 32'd5);
    check_eq("t6_undo_upd", 32'(update_pulse), 32'd1);
    @(negedge clk); undo_i = 1'b1;
    @(negedge clk); undo_i = 1'b0;
    cyc(1);
    check_eq("t6_undo2_upd_e1", 32'(update_pulse), 32'd0);
    cyc(1);
    check_eq("t6_undo2_upd_e2", 32'(update_pulse), 32'd0);
    check_eq("t6_undo2_s1", 32'(score_team1), 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
